// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot loader: FSM states and memory geometry.
package boot_pkg;
  typedef enum logic [2:0] {
    S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int MEM_WORDS_DEF = 131072;
  localparam int ADDR_W_DEF    = 19;
endpackage

// File: rtl/boot_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; word_valid fires with the 4th byte.
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [31:0] shreg;

  // Bytes enter at the top and shift down, so the first byte ends up in [7:0].
  assign word       = {byte_in, shreg[31:8]};
  assign word_valid = byte_valid && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (byte_valid) begin
      cnt   <= cnt + 2'd1;
      shreg <= word;
    end
  end
endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed image into memory and releases the core once loaded.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader
  import boot_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        restart,
  output logic        store_flag,
  output logic        byte_flag,
  output logic [31:0] addr,
  output logic [31:0] data_store,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);
  localparam int WI_W = ADDR_W - 2;
  localparam int LW   = $clog2(MEM_WORDS + 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t TAIL = S_CSUM;
  logic [7:0] csum;
`else
  localparam state_t TAIL = S_DONE;
`endif

  state_t          state, state_nx;
  logic            accept, asm_valid, asm_clear, word_valid;
  logic [31:0]     word;
  logic [WI_W-1:0] word_idx;
  logic [LW-1:0]   words_left;
  logic [31:0]     data_q;

  assign in_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign accept    = in_valid && in_ready;
  assign asm_valid = accept && ((state == S_HDR) || (state == S_DATA));
  assign asm_clear = restart && ((state == S_DONE) || (state == S_ERR));

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR: if (word_valid) begin
        if (word == 32'd0)                 state_nx = TAIL;
        else if (word > 32'(MEM_WORDS))    state_nx = S_ERR;
        else                               state_nx = S_DATA;
      end
      S_DATA:  if (word_valid) state_nx = S_WRITE;
      S_WRITE: state_nx = (words_left == LW'(1)) ? TAIL : S_DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM:  if (accept) state_nx = (in_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (restart) state_nx = S_HDR;
      default: state_nx = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx   <= '0;
      words_left <= '0;
      data_q     <= '0;
    end else begin
      if (asm_clear) word_idx <= '0;
      // Oversize headers load a truncated count but never reach WRITE.
      if (state == S_HDR && word_valid)  words_left <= word[LW-1:0];
      if (state == S_DATA && word_valid) data_q <= word;
      if (state == S_WRITE) begin
        word_idx   <= word_idx + WI_W'(1);
        words_left <= words_left - LW'(1);
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         csum <= '0;
    else if (asm_clear)                 csum <= '0;
    else if (state == S_DATA && accept) csum <= csum ^ in_data;
  end
`endif

  assign store_flag = (state == S_WRITE);
  assign byte_flag  = 1'b0;
  assign addr       = {{(32-ADDR_W){1'b0}}, word_idx, 2'b00};
  assign data_store = data_q;
  assign cpu_rst_n  = (state == S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
endmodule
